// File: rtl/synaptic_accumulator.sv
// Spike-event accumulator: queues source IDs, looks up float weights and sums
// them per timestep, publishing the total with a one-cycle valid pulse.

module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        add_sub,
  output logic        exception,
  output logic [31:0] result
);
  logic        b_sign, a_is_big, big_sign, small_sign, eff_sub, overflow;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  big_exp, small_exp, exp_diff;
  logic [26:0] big_sig, small_sig, small_aligned, diff_sig, norm_sig;
  logic [27:0] sum_sig;
  logic [4:0]  lz;
  logic [9:0]  res_exp;
  logic [22:0] res_man;

  // Denormals are flushed to zero; three guard bits below the mantissa.
  function automatic logic [26:0] unpack_sig(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
  endfunction

  function automatic logic [4:0] lead_zeros(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i <= 26; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  always_comb begin
    b_sign        = b_operand[31] ^ add_sub;
    a_is_big      = a_operand[30:0] >= b_operand[30:0];
    big_sign      = a_is_big ? a_operand[31] : b_sign;
    small_sign    = a_is_big ? b_sign : a_operand[31];
    big_exp       = a_is_big ? a_operand[30:23] : b_operand[30:23];
    small_exp     = a_is_big ? b_operand[30:23] : a_operand[30:23];
    big_sig       = a_is_big ? unpack_sig(a_operand) : unpack_sig(b_operand);
    small_sig     = a_is_big ? unpack_sig(b_operand) : unpack_sig(a_operand);
    exp_diff      = big_exp - small_exp;
    small_aligned = (exp_diff > 8'd26) ? 27'd0 : (small_sig >> exp_diff);
    eff_sub       = big_sign ^ small_sign;
    sum_sig       = {1'b0, big_sig} + {1'b0, small_aligned};
    diff_sig      = big_sig - small_aligned;
    lz            = lead_zeros(diff_sig);
    norm_sig      = diff_sig << lz;
    res_exp       = {2'b00, big_exp};
    res_man       = 23'd0;
    overflow      = 1'b0;

    if (!eff_sub) begin
      if (sum_sig[27]) begin
        res_man = sum_sig[26:4];
        res_exp = {2'b00, big_exp} + 10'd1;
      end else begin
        res_man = sum_sig[25:3];
      end
    end else if (diff_sig == 27'd0) begin
      res_exp = 10'd0;
    end else begin
      res_man = norm_sig[25:3];
      res_exp = {2'b00, big_exp} - {5'd0, lz};
    end

    if (res_exp == 10'd0 || res_exp[9]) begin
      result = 32'd0;
    end else if (res_exp >= 10'd255) begin
      result   = {big_sign, 8'hFF, 23'd0};
      overflow = 1'b1;
    end else begin
      result = {big_sign, res_exp[7:0], res_man};
    end

    a_nan = (&a_operand[30:23]) && (|a_operand[22:0]);
    b_nan = (&b_operand[30:23]) && (|b_operand[22:0]);
    a_inf = (&a_operand[30:23]) && !(|a_operand[22:0]);
    b_inf = (&b_operand[30:23]) && !(|b_operand[22:0]);
    if (a_nan || b_nan || (a_inf && b_inf && (a_operand[31] != b_sign)))
      result = 32'h7FC0_0000;
    else if (a_inf)
      result = {a_operand[31], 8'hFF, 23'd0};
    else if (b_inf)
      result = {b_sign, 8'hFF, 23'd0};

    exception = overflow || (&a_operand[30:23]) || (&b_operand[30:23]);
  end
endmodule

// state   | meaning
// IDLE    | waiting; dispatch next event or publish a closed timestep
// FETCH   | pop FIFO head, read its weight
// ADD     | fold fetched weight into the running sum
// PUBLISH | input_weight/weight_valid visible, sum cleared
module synaptic_accumulator #(
  parameter int NUM_INPUTS = 16,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                weight_wr_en,
  input  logic [ID_WIDTH-1:0] weight_wr_addr,
  input  logic [31:0]         weight_wr_data,
  input  logic                spike_valid,
  input  logic [ID_WIDTH-1:0] spike_src_id,
  output logic                spike_ready,
  input  logic                timestep_end,
  output logic [31:0]         input_weight,
  output logic                weight_valid,
  output logic                busy,
  output logic                err_ts_overrun,
  output logic                err_fp,
  output logic                err_bad_id
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [ID_WIDTH:0] NUM_IN_L = (ID_WIDTH + 1)'(NUM_INPUTS);

  typedef enum logic [1:0] {IDLE, FETCH, ADD, PUBLISH} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                fifo_full, fifo_empty, push;
  logic [ID_WIDTH-1:0] head_id;
  logic                ts_pending, skip_add;
  logic [31:0]         weight_ram [NUM_INPUTS];
  logic [31:0]         rdata, acc, add_result;
  logic                add_exc;

  function automatic logic id_ok(input logic [ID_WIDTH-1:0] id);
    return {1'b0, id} < NUM_IN_L;
  endfunction

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign spike_ready = !fifo_full && !ts_pending;
  assign push        = spike_valid && spike_ready;
  assign head_id     = fifo_mem[rd_ptr[AW-1:0]];
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= spike_src_id;
  end

  // Weight RAM is not reset; a same-cycle write and fetch sees the old word.
  always_ff @(posedge clk) begin
    if (weight_wr_en && id_ok(weight_wr_addr))
      weight_ram[weight_wr_addr] <= weight_wr_data;
    if (state == FETCH && id_ok(head_id))
      rdata <= weight_ram[head_id];
  end

  Addition_Subtraction u_add (
    .a_operand (acc),
    .b_operand (rdata),
    .add_sub   (1'b0),
    .exception (add_exc),
    .result    (add_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ts_pending     <= 1'b0;
      skip_add       <= 1'b0;
      acc            <= 32'd0;
      input_weight   <= 32'd0;
      weight_valid   <= 1'b0;
      err_ts_overrun <= 1'b0;
      err_fp         <= 1'b0;
      err_bad_id     <= 1'b0;
    end else begin
      weight_valid <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!id_ok(spike_src_id)) err_bad_id <= 1'b1;
      end
      if (timestep_end) begin
        if (ts_pending) err_ts_overrun <= 1'b1;
        else            ts_pending     <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= FETCH;
          end else if (ts_pending) begin
            state        <= PUBLISH;
            input_weight <= acc;
            weight_valid <= 1'b1;
          end
        end
        FETCH: begin
          rd_ptr   <= rd_ptr + 1'b1;
          skip_add <= !id_ok(head_id);
          state    <= ADD;
        end
        ADD: begin
          if (!skip_add) begin
            acc    <= add_result;
            err_fp <= err_fp | add_exc;
          end
          state <= IDLE;
        end
        PUBLISH: begin
          // A timestep_end landing here was already flagged as an overrun.
          acc        <= 32'd0;
          ts_pending <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_synaptic_accumulator.sv
// Directed and randomized checks of synaptic_accumulator against a real-valued
// per-timestep sum model.

module tb_synaptic_accumulator;
  localparam int NI = 12;
  localparam int IW = 4;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          weight_wr_en = 1'b0;
  logic [IW-1:0] weight_wr_addr = '0;
  logic [31:0]   weight_wr_data = '0;
  logic          spike_valid = 1'b0;
  logic [IW-1:0] spike_src_id = '0;
  logic          spike_ready;
  logic          timestep_end = 1'b0;
  logic [31:0]   input_weight;
  logic          weight_valid;
  logic          busy;
  logic          err_ts_overrun, err_fp, err_bad_id;

  int  tests = 0;
  int  fails = 0;
  int  stall_cycles = 0;
  real w_model [NI];
  real exp_sum = 0.0;

  always #5 clk = ~clk;

  synaptic_accumulator #(.NUM_INPUTS(NI), .ID_WIDTH(IW), .FIFO_DEPTH(FD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .weight_wr_en   (weight_wr_en),
    .weight_wr_addr (weight_wr_addr),
    .weight_wr_data (weight_wr_data),
    .spike_valid    (spike_valid),
    .spike_src_id   (spike_src_id),
    .spike_ready    (spike_ready),
    .timestep_end   (timestep_end),
    .input_weight   (input_weight),
    .weight_valid   (weight_valid),
    .busy           (busy),
    .err_ts_overrun (err_ts_overrun),
    .err_fp         (err_fp),
    .err_bad_id     (err_bad_id)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Exact single-precision encoding of values that need no rounding.
  function automatic logic [31:0] to_f32(input real v);
    real  m;
    int   e;
    int   frac;
    logic s;
    if (v == 0.0) return 32'd0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    frac = $rtoi((m - 1.0) * 8388608.0);
    return {s, 8'(e + 127), frac[22:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_raw(input int id, input logic [31:0] data);
    weight_wr_en   = 1'b1;
    weight_wr_addr = IW'(id);
    weight_wr_data = data;
    tick();
    weight_wr_en = 1'b0;
  endtask

  task automatic write_w(input int id, input real v);
    write_raw(id, to_f32(v));
    if (id < NI) w_model[id] = v;
  endtask

  task automatic send_spike(input int id);
    int n;
    n = 0;
    spike_valid  = 1'b1;
    spike_src_id = IW'(id);
    while (!spike_ready && n < 200) begin
      tick();
      n++;
      stall_cycles++;
    end
    check("spike_accept", {31'd0, spike_ready}, 32'd1);
    tick();
    spike_valid = 1'b0;
    if (id < NI) exp_sum += w_model[id];
  endtask

  task automatic pulse_ts();
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
  endtask

  task automatic expect_publish(input string tag, input logic [31:0] exp);
    int n;
    int extra;
    n = 0;
    while (!weight_valid && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, weight_valid}, 32'd1);
    check(tag, input_weight, exp);
    extra = 0;
    repeat (10) begin
      tick();
      if (weight_valid) extra++;
    end
    check({tag, "_single_pulse"}, extra, 32'd0);
    exp_sum = 0.0;
  endtask

  initial begin
    int cnt;
    int nev;

    repeat (3) tick();
    check("rst_input_weight", input_weight, 32'd0);
    check("rst_flags", {27'd0, weight_valid, busy, err_ts_overrun, err_fp, err_bad_id}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", {31'd0, spike_ready}, 32'd1);

    // 1.0 + 2.5
    write_w(0, 1.0);
    write_w(1, 2.5);
    send_spike(0);
    send_spike(1);
    pulse_ts();
    expect_publish("ts_basic", 32'h4060_0000);

    // Empty timestep: exact two-cycle latency, zero result
    pulse_ts();
    check("empty_lat1", {31'd0, weight_valid}, 32'd0);
    tick();
    check("empty_lat2", {31'd0, weight_valid}, 32'd1);
    check("empty_sum", input_weight, 32'd0);
    repeat (3) tick();

    // Nine events of 20.0
    write_w(2, 20.0);
    repeat (9) send_spike(2);
    pulse_ts();
    expect_publish("ts_nine", 32'h4334_0000);

    // Long burst must fill the FIFO and exert backpressure
    stall_cycles = 0;
    repeat (16) send_spike(0);
    check("backpressure_seen", {31'd0, stall_cycles > 0}, 32'd1);
    pulse_ts();
    expect_publish("ts_burst16", 32'h4180_0000);

    // Spike coincident with timestep_end, then an overrun pulse
    spike_valid  = 1'b1;
    spike_src_id = IW'(1);
    timestep_end = 1'b1;
    tick();
    spike_valid  = 1'b0;
    timestep_end = 1'b0;
    check("ready_drop", {31'd0, spike_ready}, 32'd0);
    pulse_ts();
    expect_publish("ts_coincident", 32'h4020_0000);
    check("err_ts_overrun", {31'd0, err_ts_overrun}, 32'd1);
    check("idle_after_publish", {31'd0, busy}, 32'd0);

    // Out-of-range ID contributes nothing
    check("bad_id_before", {31'd0, err_bad_id}, 32'd0);
    send_spike(15);
    send_spike(0);
    pulse_ts();
    expect_publish("ts_bad_id", 32'h3F80_0000);
    check("err_bad_id", {31'd0, err_bad_id}, 32'd1);
    check("err_fp_clean", {31'd0, err_fp}, 32'd0);

    // max_float + max_float overflows to +Inf
    write_raw(3, 32'h7F7F_FFFF);
    send_spike(3);
    send_spike(3);
    pulse_ts();
    expect_publish("ts_overflow", 32'h7F80_0000);
    check("err_fp", {31'd0, err_fp}, 32'd1);

    // Reset mid-drain
    repeat (4) send_spike(0);
    pulse_ts();
    tick();
    rst_n = 1'b0;
    #2;
    check("midrst_input_weight", input_weight, 32'd0);
    check("midrst_flags", {27'd0, weight_valid, busy, err_ts_overrun, err_fp, err_bad_id}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ready", {31'd0, spike_ready}, 32'd1);
    cnt = 0;
    repeat (30) begin
      tick();
      if (weight_valid) cnt++;
    end
    check("midrst_no_publish", cnt, 32'd0);
    exp_sum = 0.0;

    // Weight RAM survives reset
    send_spike(1);
    pulse_ts();
    expect_publish("ram_retained", 32'h4020_0000);

    // Randomized timesteps with signed quarter-step weights
    for (int id = 0; id < NI; id++)
      write_w(id, real'(int'($urandom_range(0, 256)) - 128) / 4.0);
    for (int ts = 0; ts < 6; ts++) begin
      nev = int'($urandom_range(0, 14));
      for (int k = 0; k < nev; k++) begin
        send_spike(int'($urandom_range(0, NI - 1)));
        if ($urandom_range(0, 3) == 0) tick();
      end
      pulse_ts();
      expect_publish($sformatf("rand_ts%0d", ts), to_f32(exp_sum));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
